// File: rtl/add_pkg.sv
// Shared types and saturation helpers for the round-robin adder scheduler.
// Used by add_rr_sched when ADD_RR_SCHED_SAT_EN is defined.
package add_pkg;

  localparam int WORD_BITS    = 64;
  localparam int ADD_NREQ_MAX = 16;

  typedef logic [WORD_BITS-1:0] word_t;

  // Largest positive value of a bits-wide signed word, zero-extended.
  function automatic word_t sat_max(int bits);
    return ~word_t'(0) >> (WORD_BITS - bits + 1);
  endfunction

  // Most negative value; only the low bits-wide slice is meaningful.
  function automatic word_t sat_min(int bits);
    return word_t'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/add_rca_signed.sv
// Signed ripple-carry adder; the final carry-out is dropped since
// callers derive signed overflow from the operand and sum sign bits.
module add_rca_signed #(
  parameter int Bits = 64
) (
  input  logic [Bits-1:0] a,
  input  logic [Bits-1:0] b,
  input  logic            cin,
  output logic [Bits-1:0] sum
);

  logic [Bits-1:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < Bits; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      if (i < Bits - 1)
        c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first request at or after the
// pointer, then moves the pointer just past the winner.
module rr_arbiter #(
  parameter  int NReq   = 4,
  localparam int IdBits = $clog2(NReq)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NReq-1:0]   req,
  input  logic              en,
  output logic [NReq-1:0]   gnt,
  output logic [IdBits-1:0] gnt_idx
);

  logic [IdBits-1:0] ptr;
  logic [IdBits-1:0] jx;
  logic              found;
  int                j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    jx      = '0;
    for (int k = 0; k < NReq; k++) begin
      j = int'(ptr) + k;
      if (j >= NReq)
        j = j - NReq;
      jx = IdBits'(j);
      if (en && !found && req[jx]) begin
        gnt[jx] = 1'b1;
        gnt_idx = jx;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (found)
      ptr <= (gnt_idx == IdBits'(NReq - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/add_rr_sched.sv
// Round-robin scheduler sharing one signed adder among NReq requesters.
// ADD_RR_SCHED_SAT_EN: clamp overflowing sums to the signed limits.
module add_rr_sched
  import add_pkg::*;
#(
  parameter  int Bits   = 64,
  parameter  int NReq   = 4,
  localparam int IdBits = $clog2(NReq)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NReq-1:0]      req_valid,
  output logic [NReq-1:0]      req_ready,
  input  logic [NReq*Bits-1:0] req_a,
  input  logic [NReq*Bits-1:0] req_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Bits-1:0]      out_sum,
  output logic                 out_ovf,
  output logic [IdBits-1:0]    out_id
);

  logic              stage_free;
  logic              en;
  logic              any_gnt;
  logic [IdBits-1:0] gidx;
  logic [Bits-1:0]   op_a;
  logic [Bits-1:0]   op_b;
  logic [Bits-1:0]   raw_sum;
  logic [Bits-1:0]   res_sum;
  logic              ovf;

  assign stage_free = !out_valid || out_ready;
  assign en         = stage_free && !reset;
  assign any_gnt    = |req_ready;

  rr_arbiter #(.NReq(NReq)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (en),
    .gnt     (req_ready),
    .gnt_idx (gidx)
  );

  assign op_a = req_a[gidx*Bits +: Bits];
  assign op_b = req_b[gidx*Bits +: Bits];

  add_rca_signed #(.Bits(Bits)) u_add (
    .a   (op_a),
    .b   (op_b),
    .cin (1'b0),
    .sum (raw_sum)
  );

  assign ovf = (op_a[Bits-1] == op_b[Bits-1]) &&
               (raw_sum[Bits-1] != op_a[Bits-1]);

`ifdef ADD_RR_SCHED_SAT_EN
  word_t smax_w;
  word_t smin_w;

  assign smax_w = sat_max(Bits);
  assign smin_w = sat_min(Bits);

  always_comb begin
    res_sum = raw_sum;
    if (ovf)
      res_sum = op_a[Bits-1] ? smin_w[Bits-1:0] : smax_w[Bits-1:0];
  end
`else
  assign res_sum = raw_sum;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_id    <= '0;
    end else if (any_gnt) begin
      out_valid <= 1'b1;
      out_sum   <= res_sum;
      out_ovf   <= ovf;
      out_id    <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_rr_sched.sv
// Directed bench for add_rr_sched with Bits=8, NReq=4.
// Honours ADD_RR_SCHED_SAT_EN for the clamped-sum expectations.
module tb_add_rr_sched;

  localparam int Bits = 8;
  localparam int NReq = 4;

`ifdef ADD_RR_SCHED_SAT_EN
  localparam logic [7:0] S1 = 8'h7F;
  localparam logic [7:0] S2 = 8'h80;
`else
  localparam logic [7:0] S1 = 8'h80;
  localparam logic [7:0] S2 = 8'h7F;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NReq-1:0]      req_valid;
  logic [NReq-1:0]      req_ready;
  logic [NReq*Bits-1:0] req_a;
  logic [NReq*Bits-1:0] req_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [Bits-1:0]      out_sum;
  logic                 out_ovf;
  logic [1:0]           out_id;

  int nchk  = 0;
  int nfail = 0;

  add_rr_sched #(.Bits(Bits), .NReq(NReq)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [1:0] id, input logic [7:0] s,
                         input logic o);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".id"},    32'(out_id),    32'(id));
    chk({tag, ".sum"},   32'(out_sum),   32'(s));
    chk({tag, ".ovf"},   32'(out_ovf),   32'(o));
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    out_ready = 1'b1;
    req_a     = {8'hFB, 8'h80, 8'h7F, 8'h01};
    req_b     = {8'h03, 8'hFF, 8'h01, 8'h02};
    #1;
    chk_out("rst", 1'b0, 2'd0, 8'h00, 1'b0);
    chk("rst.ready", 32'(req_ready), 32'h0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t1.ready0", 32'(req_ready), 32'h1);

    tick();
    chk_out("t1.g0", 1'b1, 2'd0, 8'h03, 1'b0);
    chk("t1.ready1", 32'(req_ready), 32'h2);
    tick();
    chk_out("t2.g1", 1'b1, 2'd1, S1, 1'b1);
    tick();
    chk_out("t2.g2", 1'b1, 2'd2, S2, 1'b1);
    tick();
    chk_out("t6.g3", 1'b1, 2'd3, 8'hFE, 1'b0);
    tick();
    chk_out("t1.g0b", 1'b1, 2'd0, 8'h03, 1'b0);

    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3.ready", 32'(req_ready), 32'h0);
      tick();
      chk_out("t3.hold", 1'b1, 2'd0, 8'h03, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3.rel", 32'(req_ready), 32'h2);
    tick();
    chk_out("t3.g1", 1'b1, 2'd1, S1, 1'b1);

    req_valid = 4'h8;
    #1;
    chk("t4.ready3", 32'(req_ready), 32'h8);
    tick();
    chk_out("t4.g3", 1'b1, 2'd3, 8'hFE, 1'b0);
    req_valid = 4'h9;
    #1;
    chk("t4.ready0", 32'(req_ready), 32'h1);
    tick();
    chk_out("t4.g0", 1'b1, 2'd0, 8'h03, 1'b0);
    #1;
    chk("t4.ready3b", 32'(req_ready), 32'h8);
    tick();
    chk_out("t4.g3b", 1'b1, 2'd3, 8'hFE, 1'b0);

    req_valid = 4'h0;
    #1;
    chk("idle.ready", 32'(req_ready), 32'h0);
    tick();
    chk("drain.valid", 32'(out_valid), 32'h0);
    req_valid = 4'h2;
    #1;
    chk("ptr.held", 32'(req_ready), 32'h2);
    tick();
    chk_out("t4.g1", 1'b1, 2'd1, S1, 1'b1);

    req_valid = 4'hF;
    #1;
    chk("t5.ready2", 32'(req_ready), 32'h4);
    tick();
    chk_out("t5.g2", 1'b1, 2'd2, S2, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("t5.async", 1'b0, 2'd0, 8'h00, 1'b0);
    chk("t5.rready", 32'(req_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5.ready0", 32'(req_ready), 32'h1);
    tick();
    chk_out("t5.g0", 1'b1, 2'd0, 8'h03, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
